// File: rtl/prci_rst_seq.sv
// Reset sequencer for the PRCI block: synchronizes and debounces the reset button,
// qualifies PLL lock, and stretches DMI reset requests into clean output levels.
module prci_rst_seq #(
  parameter int unsigned hold_cycles     = 64,
  parameter int unsigned lock_cycles     = 256,
  parameter int unsigned debounce_cycles = 1000,
  parameter int unsigned dmi_cycles      = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button,
  input  logic       i_pll_locked,
  input  logic       i_dmireset_req,
  output logic       o_pwrreset,
  output logic       o_sys_locked,
  output logic       o_dmireset,
  output logic [1:0] o_state
);

  localparam logic [15:0] HoldLast     = 16'(hold_cycles - 1);
  localparam logic [15:0] LockLast     = 16'(lock_cycles - 1);
  localparam logic [15:0] DebounceLast = 16'(debounce_cycles - 1);
  localparam logic [15:0] DmiLast      = 16'(dmi_cycles - 1);

  typedef enum logic [1:0] {
    StHold     = 2'd0,
    StWaitLock = 2'd1,
    StRun      = 2'd2,
    StDmi      = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Synchronizers
  // --------------------------------------------------------------------------
  logic [1:0] btn_sync_q;
  logic [1:0] lock_sync_q;
  logic       btn_s;
  logic       lock_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_sync_q  <= 2'b00;
      lock_sync_q <= 2'b00;
    end else begin
      btn_sync_q  <= {btn_sync_q[0], i_button};
      lock_sync_q <= {lock_sync_q[0], i_pll_locked};
    end
  end

  assign btn_s  = btn_sync_q[1];
  assign lock_s = lock_sync_q[1];

  // --------------------------------------------------------------------------
  // Button debouncer
  // --------------------------------------------------------------------------
  logic [15:0] dbcnt_q, dbcnt_d;
  logic        btn_db_q, btn_db_d;

  always_comb begin
    dbcnt_d  = dbcnt_q;
    btn_db_d = btn_db_q;
    if (btn_s == btn_db_q) begin
      dbcnt_d = 16'd0;
    end else if (dbcnt_q == DebounceLast) begin
      btn_db_d = btn_s;
      dbcnt_d  = 16'd0;
    end else begin
      dbcnt_d = dbcnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dbcnt_q  <= 16'd0;
      btn_db_q <= 1'b0;
    end else begin
      dbcnt_q  <= dbcnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM with one shared counter
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHold: begin
        if (btn_db_q) begin
          cnt_d = 16'd0;
        end else if (cnt_q == HoldLast) begin
          state_d = StWaitLock;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitLock: begin
        if (btn_db_q) begin
          state_d = StHold;
          cnt_d   = 16'd0;
        end else if (!lock_s) begin
          cnt_d = 16'd0;
        end else if (cnt_q == LockLast) begin
          state_d = StRun;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StRun: begin
        if (btn_db_q || !lock_s) begin
          state_d = StHold;
          cnt_d   = 16'd0;
        end else if (i_dmireset_req) begin
          state_d = StDmi;
          cnt_d   = 16'd0;
        end
      end
      StDmi: begin
        if (btn_db_q || !lock_s) begin
          state_d = StHold;
          cnt_d   = 16'd0;
        end else if (i_dmireset_req) begin
          // A fresh request restarts the full pulse width.
          cnt_d = 16'd0;
        end else if (cnt_q == DmiLast) begin
          state_d = StRun;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch with the state.
  logic pwrreset_q, sys_locked_q, dmireset_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StHold;
      cnt_q        <= 16'd0;
      pwrreset_q   <= 1'b1;
      sys_locked_q <= 1'b0;
      dmireset_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pwrreset_q   <= (state_d == StHold) || (state_d == StWaitLock);
      sys_locked_q <= (state_d == StRun) || (state_d == StDmi);
      dmireset_q   <= (state_d == StDmi);
    end
  end

  assign o_pwrreset   = pwrreset_q;
  assign o_sys_locked = sys_locked_q;
  assign o_dmireset   = dmireset_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_prci_rst_seq.sv
// Directed bench for prci_rst_seq: expected output snapshots are queued with their
// due cycle and compared when the clock reaches that cycle.
module tb_prci_rst_seq;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_button;
  logic       i_pll_locked;
  logic       i_dmireset_req;
  logic       o_pwrreset;
  logic       o_sys_locked;
  logic       o_dmireset;
  logic [1:0] o_state;

  // {pwrreset, sys_locked, dmireset, state}
  localparam logic [4:0] EHold = 5'b1_0_0_00;
  localparam logic [4:0] EWait = 5'b1_0_0_01;
  localparam logic [4:0] ERun  = 5'b0_1_0_10;
  localparam logic [4:0] EDmi  = 5'b0_1_1_11;

  int         q_cyc[$];
  logic [4:0] q_exp[$];
  string      q_tag[$];

  int cyc   = 0;
  int base  = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  prci_rst_seq dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_button       (i_button),
    .i_pll_locked   (i_pll_locked),
    .i_dmireset_req (i_dmireset_req),
    .o_pwrreset     (o_pwrreset),
    .o_sys_locked   (o_sys_locked),
    .o_dmireset     (o_dmireset),
    .o_state        (o_state)
  );

  task automatic push(input int rel, input string tag, input logic [4:0] exp);
    q_cyc.push_back(base + rel);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  task automatic tick();
    int         due;
    logic [4:0] exp;
    logic [4:0] obs;
    string      tag;
    @(posedge i_clk);
    #1;
    cyc++;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      due = q_cyc.pop_front();
      exp = q_exp.pop_front();
      tag = q_tag.pop_front();
      obs = {o_pwrreset, o_sys_locked, o_dmireset, o_state};
      n_cmp++;
      assert (obs === exp && due == cyc) else begin
        n_bad++;
        $error("FAIL %s at cycle %0d (due %0d): observed %b required %b", tag, cyc, due, obs,
               exp);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    i_rst          = 1'b1;
    i_button       = 1'b0;
    i_pll_locked   = 1'b1;
    i_dmireset_req = 1'b0;

    // Reset values
    base = cyc;
    push(1, "rst_vals", EHold);
    push(3, "rst_vals_hold", EHold);
    run(3);

    // Power-up release: 64 + 256 cycles to RUN
    i_rst = 1'b0;
    base  = cyc;
    push(1, "pu_edge1", EHold);
    push(63, "pu_hold_end", EHold);
    push(64, "pu_wait", EWait);
    push(319, "pu_wait_end", EWait);
    push(320, "pu_run", ERun);
    push(321, "pu_run_stay", ERun);
    run(321);

    // Single-cycle DMI request
    base = cyc;
    push(1, "dmi_start", EDmi);
    push(16, "dmi_last", EDmi);
    push(17, "dmi_end", ERun);
    i_dmireset_req = 1'b1;
    tick();
    i_dmireset_req = 1'b0;
    run(20);

    // Second request at cycle 10 of the pulse
    base = cyc;
    push(9, "dmiext_mid", EDmi);
    push(17, "dmiext_old_end", EDmi);
    push(25, "dmiext_last", EDmi);
    push(26, "dmiext_end", ERun);
    i_dmireset_req = 1'b1;
    tick();
    i_dmireset_req = 1'b0;
    run(8);
    i_dmireset_req = 1'b1;
    tick();
    i_dmireset_req = 1'b0;
    run(20);

    // Button bounce of 500 cycles is ignored
    base = cyc;
    push(250, "bounce_mid", ERun);
    push(1100, "bounce_after", ERun);
    i_button = 1'b1;
    run(500);
    i_button = 1'b0;
    run(600);

    // Long press: reset at debounce + 3
    base = cyc;
    push(1002, "press_pre", ERun);
    push(1003, "press_hold", EHold);
    push(1200, "press_held", EHold);
    i_button = 1'b1;
    run(1200);
    i_button = 1'b0;
    base = cyc;
    push(1002, "release_db", EHold);
    push(1065, "release_hold_end", EHold);
    push(1066, "release_wait", EWait);
    push(1321, "release_wait_end", EWait);
    push(1322, "release_run", ERun);
    run(1325);

    // One-cycle lock loss
    base = cyc;
    push(2, "lock_pre", ERun);
    push(3, "lock_lost", EHold);
    push(66, "lock_hold_end", EHold);
    push(67, "lock_wait", EWait);
    push(322, "lock_wait_end", EWait);
    push(323, "lock_run", ERun);
    i_pll_locked = 1'b0;
    tick();
    i_pll_locked = 1'b1;
    run(325);

    // Button pressed while in DMI (request held to stay there)
    base = cyc;
    push(1, "dmibtn_dmi", EDmi);
    push(1002, "dmibtn_pre", EDmi);
    push(1003, "dmibtn_hold", EHold);
    i_dmireset_req = 1'b1;
    i_button       = 1'b1;
    run(1003);
    i_dmireset_req = 1'b0;
    i_button       = 1'b0;
    base = cyc;
    push(1322, "dmibtn_run", ERun);
    run(1325);

    // Lock loss while in DMI
    base = cyc;
    push(3, "dmilock_pre", EDmi);
    push(4, "dmilock_hold", EHold);
    push(323, "dmilock_wait", EWait);
    push(324, "dmilock_run", ERun);
    i_dmireset_req = 1'b1;
    tick();
    i_dmireset_req = 1'b0;
    i_pll_locked   = 1'b0;
    tick();
    i_pll_locked = 1'b1;
    run(325);

    // i_rst in RUN
    base = cyc;
    push(1, "rstrun_vals", EHold);
    push(320, "rstrun_wait", EWait);
    push(321, "rstrun_run", ERun);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    run(322);

    // i_rst in DMI
    base = cyc;
    push(1, "rstdmi_dmi", EDmi);
    push(2, "rstdmi_vals", EHold);
    push(321, "rstdmi_wait", EWait);
    push(322, "rstdmi_run", ERun);
    i_dmireset_req = 1'b1;
    tick();
    i_dmireset_req = 1'b0;
    i_rst          = 1'b1;
    tick();
    i_rst = 1'b0;
    run(322);

    // i_rst in HOLD restarts the hold count
    base = cyc;
    push(1, "rsthold_first", EHold);
    push(40, "rsthold_pre", EHold);
    push(41, "rsthold_vals", EHold);
    push(321, "rsthold_late_wait", EWait);
    push(360, "rsthold_wait_end", EWait);
    push(361, "rsthold_run", ERun);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    run(39);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    run(322);

    // i_rst in WAIT_LOCK
    base = cyc;
    push(150, "rstwait_pre", EWait);
    push(151, "rstwait_vals", EHold);
    push(214, "rstwait_hold_end", EHold);
    push(215, "rstwait_wait", EWait);
    push(470, "rstwait_wait_end", EWait);
    push(471, "rstwait_run", ERun);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    run(149);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    run(322);

    if (q_cyc.size() > 0) begin
      n_bad += q_cyc.size();
      $display("FAIL scoreboard_drain: %0d pending expectations, required 0", q_cyc.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
